// File: rtl/dense_layer_seq.sv
// rtl/dense_layer_seq.sv - time-multiplexed dense layer sequencer with one shared MAC
// Optional build macro: DENSE_SEQ_SATURATE_EN (clamp results instead of wrapping)
module dense_layer_seq #(
  parameter int B     = 2,
  parameter int M     = 3,
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  localparam int WAW  = (M * N > 1) ? $clog2(M * N) : 1,
  localparam int XAW  = (B * N > 1) ? $clog2(B * N) : 1,
  localparam int BAW  = (M > 1) ? $clog2(M) : 1,
  localparam int RAW  = (B * M > 1) ? $clog2(B * M) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             w_re,
  output logic [WAW-1:0]   w_addr,
  input  logic [WIDTH-1:0] w_rdata,
  output logic             x_re,
  output logic [XAW-1:0]   x_addr,
  input  logic [WIDTH-1:0] x_rdata,
  output logic             b_re,
  output logic [BAW-1:0]   b_addr,
  input  logic [WIDTH-1:0] b_rdata,
  output logic             res_we,
  output logic [RAW-1:0]   res_addr,
  output logic [WIDTH-1:0] res_wdata
);

  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = 2 * WIDTH;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_t;

  state_t state, state_nxt;

  logic [BW-1:0] b_cnt, b_nxt;
  logic [MW-1:0] m_cnt, m_nxt;
  logic [NW-1:0] n_cnt, n_nxt;

  logic signed [AW-1:0]  acc;
  logic        [WIDTH-1:0] bias_q;
  logic                  prod_vld;
  logic                  bias_vld;

  logic signed [AW-1:0] w_ext;
  logic signed [AW-1:0] x_ext;
  logic signed [AW-1:0] prod;
  logic signed [AW-1:0] bias_ext;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] sum_sh;
  logic [WIDTH-1:0]     res_val;

  // Full-width signed product of the SRAM words returned this cycle
  assign w_ext = {{WIDTH{w_rdata[WIDTH-1]}}, w_rdata};
  assign x_ext = {{WIDTH{x_rdata[WIDTH-1]}}, x_rdata};
  assign prod  = w_ext * x_ext;

  // Bias is aligned to the product's Q(2*FRAC) point, then the sum is floored back to Q(FRAC)
  assign bias_ext = {{WIDTH{bias_q[WIDTH-1]}}, bias_q};
  assign sum      = acc + (bias_ext <<< FRAC);
  assign sum_sh   = sum >>> FRAC;

`ifdef DENSE_SEQ_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

  // Clamp the full-precision result into the signed WIDTH range
  always_comb begin
    res_val = sum_sh[WIDTH-1:0];
    if (sum_sh > SAT_MAX) begin
      res_val = SAT_MAX[WIDTH-1:0];
    end else if (sum_sh < SAT_MIN) begin
      res_val = SAT_MIN[WIDTH-1:0];
    end
  end
`else
  logic sat_unused;

  // Wrap: only the low WIDTH bits of the shifted sum reach the result buffer
  assign res_val    = sum_sh[WIDTH-1:0];
  assign sat_unused = ^sum_sh[AW-1:WIDTH];
`endif

  // State and loop counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      b_cnt <= '0;
      m_cnt <= '0;
      n_cnt <= '0;
    end else begin
      state <= state_nxt;
      b_cnt <= b_nxt;
      m_cnt <= m_nxt;
      n_cnt <= n_nxt;
    end
  end

  // Next-state and counter sequencing: N reads per element, then drain and write
  always_comb begin
    state_nxt = state;
    b_nxt     = b_cnt;
    m_nxt     = m_cnt;
    n_nxt     = n_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          b_nxt     = '0;
          m_nxt     = '0;
          n_nxt     = '0;
        end
      end
      RUN: begin
        if (n_cnt == NW'(N - 1)) begin
          n_nxt     = '0;
          state_nxt = DRAIN;
        end else begin
          n_nxt = n_cnt + 1'b1;
        end
      end
      DRAIN: begin
        state_nxt = WRITE;
      end
      WRITE: begin
        if (m_cnt != MW'(M - 1)) begin
          m_nxt     = m_cnt + 1'b1;
          state_nxt = RUN;
        end else begin
          m_nxt = '0;
          if (b_cnt != BW'(B - 1)) begin
            b_nxt     = b_cnt + 1'b1;
            state_nxt = RUN;
          end else begin
            b_nxt     = '0;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // SRAM read strobes, result write and status, all decoded from the current state
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    w_re      = 1'b0;
    x_re      = 1'b0;
    b_re      = 1'b0;
    w_addr    = '0;
    x_addr    = '0;
    b_addr    = '0;
    res_we    = 1'b0;
    res_addr  = '0;
    res_wdata = '0;
    if (state == RUN) begin
      w_re   = 1'b1;
      x_re   = 1'b1;
      w_addr = WAW'(int'(m_cnt) * N + int'(n_cnt));
      x_addr = XAW'(int'(b_cnt) * N + int'(n_cnt));
      if (n_cnt == '0) begin
        b_re   = 1'b1;
        b_addr = BAW'(m_cnt);
      end
    end
    if (state == WRITE) begin
      res_we    = 1'b1;
      res_addr  = RAW'(int'(b_cnt) * M + int'(m_cnt));
      res_wdata = res_val;
    end
  end

  // Track which SRAM reads return data this cycle (one-cycle read latency)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_vld <= 1'b0;
      bias_vld <= 1'b0;
    end else begin
      prod_vld <= (state == RUN);
      bias_vld <= b_re;
    end
  end

  // Capture the bias word in the cycle it comes back from the SRAM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_q <= '0;
    end else if (bias_vld) begin
      bias_q <= b_rdata;
    end
  end

  // Shared accumulator: cleared at pass start and after every write, wraps at 2*WIDTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if ((state == IDLE && start) || state == WRITE) begin
      acc <= '0;
    end else if (prod_vld) begin
      acc <= acc + prod;
    end
  end

endmodule

// File: tb/tb_dense_layer_seq.sv
// tb/tb_dense_layer_seq.sv - randomized self-checking bench for dense_layer_seq
module tb_dense_layer_seq;
  localparam int B = 2;
  localparam int M = 3;
  localparam int N = 4;
  localparam int FRAC = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // default-size instance
  logic        start = 1'b0;
  logic        busy, done, w_re, x_re, b_re, res_we;
  logic [3:0]  w_addr;
  logic [2:0]  x_addr;
  logic [1:0]  b_addr;
  logic [2:0]  res_addr;
  logic [31:0] w_rdata = '0, x_rdata = '0, b_rdata = '0, res_wdata;
  logic [31:0] wmem [M*N];
  logic [31:0] xmem [B*N];
  logic [31:0] bmem [M];
  logic [31:0] res_seen [B*M];

  dense_layer_seq #(.B(B), .M(M), .N(N), .WIDTH(32), .FRAC(FRAC)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .w_re(w_re), .w_addr(w_addr), .w_rdata(w_rdata),
    .x_re(x_re), .x_addr(x_addr), .x_rdata(x_rdata),
    .b_re(b_re), .b_addr(b_addr), .b_rdata(b_rdata),
    .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata)
  );

  always @(posedge clk) begin
    if (w_re) w_rdata <= wmem[w_addr];
    if (x_re) x_rdata <= xmem[x_addr];
    if (b_re) b_rdata <= bmem[b_addr];
  end

  // B=M=1, N=2 instance for the cycle-exact worked example
  logic        s_start = 1'b0;
  logic        s_busy, s_done, s_w_re, s_x_re, s_b_re, s_res_we;
  logic [0:0]  s_w_addr, s_x_addr, s_b_addr, s_res_addr;
  logic [31:0] s_w_rdata = '0, s_x_rdata = '0, s_b_rdata = '0, s_res_wdata;
  logic [31:0] s_wmem [2];
  logic [31:0] s_xmem [2];

  dense_layer_seq #(.B(1), .M(1), .N(2), .WIDTH(32), .FRAC(FRAC)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
    .w_re(s_w_re), .w_addr(s_w_addr), .w_rdata(s_w_rdata),
    .x_re(s_x_re), .x_addr(s_x_addr), .x_rdata(s_x_rdata),
    .b_re(s_b_re), .b_addr(s_b_addr), .b_rdata(s_b_rdata),
    .res_we(s_res_we), .res_addr(s_res_addr), .res_wdata(s_res_wdata)
  );

  always @(posedge clk) begin
    if (s_w_re) s_w_rdata <= s_wmem[s_w_addr];
    if (s_x_re) s_x_rdata <= s_xmem[s_x_addr];
    if (s_b_re) s_b_rdata <= 32'h0000_4000;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: dot product in 64-bit, add aligned bias, floor back to Q16, wrap or clamp
  function automatic logic [31:0] golden(input int b, input int m);
    longint s;
    s = 0;
    for (int n = 0; n < N; n++)
      s += longint'($signed(wmem[m*N+n])) * longint'($signed(xmem[b*N+n]));
    s += longint'($signed(bmem[m])) <<< FRAC;
    s = s >>> FRAC;
`ifdef DENSE_SEQ_SATURATE_EN
    if (s > 64'sh7FFF_FFFF) s = 64'sh7FFF_FFFF;
    if (s < -64'sh8000_0000) s = -64'sh8000_0000;
`endif
    return s[31:0];
  endfunction

  task automatic fill_random();
    foreach (wmem[i]) wmem[i] = $urandom;
    foreach (xmem[i]) xmem[i] = $urandom;
    foreach (bmem[i]) bmem[i] = $urandom;
  endtask

  // mode 0: single start pulse, 1: start held high, 2: extra pulses mid-pass
  task automatic run_pass(input int mode, input string tag);
    int t0, rel, done_rel, k;
    logic busy_ok;
    int wcyc[$];
    int wad[$];
    int wa[$];
    logic [31:0] wdat[$];
    done_rel = -1;
    busy_ok = 1'b1;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rel = cyc - t0;
      if (mode == 0) start = 1'b0;
      else if (mode == 2) start = (rel == 10 || rel == 20);
      if (!busy) busy_ok = 1'b0;
      if (w_re) wa.push_back(int'(w_addr));
      if (res_we) begin
        wad.push_back(int'(res_addr));
        wdat.push_back(res_wdata);
        wcyc.push_back(rel);
      end
      if (done) begin
        done_rel = rel;
        break;
      end
    end
    check({tag, " done_cyc"}, done_rel, B*M*(N+2)+1);
    check({tag, " busy"}, busy_ok, 1'b1);
    check({tag, " nwrites"}, wad.size(), B*M);
    check({tag, " nwreads"}, wa.size(), B*M*N);
    for (int i = 0; i < wad.size() && i < B*M; i++) begin
      check({tag, " addr"}, wad[i], i);
      check({tag, " wcyc"}, wcyc[i], (i+1)*(N+2));
      check({tag, " data"}, wdat[i], golden(i / M, i % M));
      res_seen[i] = wdat[i];
    end
    k = 0;
    for (int b = 0; b < B; b++)
      for (int m = 0; m < M; m++)
        for (int n = 0; n < N; n++) begin
          if (k < wa.size()) check({tag, " w_addr"}, wa[k], m*N+n);
          k++;
        end
    @(negedge clk);
    check({tag, " idle_after_done"}, {busy, done}, 2'b00);
    if (mode == 1) begin
      @(negedge clk);
      check({tag, " restart"}, {busy, w_re, w_addr}, {1'b1, 1'b1, 4'd0});
      start = 1'b0;
      done_rel = -1;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (done) begin
          done_rel = i;
          break;
        end
      end
      check({tag, " restart_done"}, done_rel >= 0, 1'b1);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int t0, rel, nwr, done_rel;
    logic busy_ok, quiet;
    foreach (res_seen[i]) res_seen[i] = '0;
    fill_random();
    s_wmem[0] = 32'h0001_0000; s_wmem[1] = 32'h0002_0000;
    s_xmem[0] = 32'h0003_0000; s_xmem[1] = 32'h0000_8000;

    // reset state
    #12;
    check("rst_outs", {busy, done, w_re, x_re, b_re, res_we, w_addr, x_addr, b_addr, res_addr, res_wdata}, '0);
    check("rst_small", {s_busy, s_done, s_res_we, s_res_wdata}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // worked example on the small instance
    s_start = 1'b1;
    t0 = cyc;
    nwr = 0;
    done_rel = -1;
    busy_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      s_start = 1'b0;
      rel = cyc - t0;
      if (rel >= 1 && rel <= 5 && !s_busy) busy_ok = 1'b0;
      if (s_res_we) begin
        nwr++;
        check("ex_wcyc", rel, 4);
        check("ex_addr", s_res_addr, 0);
        check("ex_data", s_res_wdata, 32'h0004_4000);
      end
      if (s_done) begin
        done_rel = rel;
        break;
      end
    end
    check("ex_done", done_rel, 5);
    check("ex_busy", busy_ok, 1'b1);
    check("ex_nwr", nwr, 1);
    @(negedge clk);
    check("ex_idle", s_busy, 1'b0);

    // random passes
    for (int p = 0; p < 3; p++) begin
      fill_random();
      run_pass(0, "rand");
    end

    // floor rounding and overflow rows
    foreach (wmem[i]) wmem[i] = '0;
    foreach (bmem[i]) bmem[i] = '0;
    wmem[0*N+0] = 32'hFFFF_FFFF;
    wmem[1*N+1] = 32'hFFFE_8000;
    wmem[2*N+2] = 32'h7FFF_0000;
    for (int b = 0; b < B; b++) begin
      xmem[b*N+0] = 32'h0000_0001;
      xmem[b*N+1] = 32'h0002_0000;
      xmem[b*N+2] = 32'h0002_0000;
      xmem[b*N+3] = $urandom;
    end
    run_pass(0, "edge");
    check("floor_neg_lsb", res_seen[0], 32'hFFFF_FFFF);
    check("floor_m1p5", res_seen[1], 32'hFFFD_0000);
`ifdef DENSE_SEQ_SATURATE_EN
    check("overflow", res_seen[2], 32'h7FFF_FFFF);
`else
    check("overflow", res_seen[2], 32'hFFFE_0000);
`endif

    // protocol: start held high, then re-pulsed mid-pass
    fill_random();
    run_pass(1, "hold");
    run_pass(2, "repulse");

    // reset in cycle 3 of the second element
    fill_random();
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc - t0 == 9) break;
    end
    check("pre_rst_busy", {busy, w_re, w_addr}, {1'b1, 1'b1, 4'd6});
    rst_n = 1'b0;
    #1;
    check("midrst_outs", {busy, done, w_re, x_re, b_re, res_we, w_addr, x_addr, b_addr, res_addr, res_wdata}, '0);
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (res_we || busy) quiet = 1'b0;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (res_we || busy) quiet = 1'b0;
    end
    check("post_rst_quiet", quiet, 1'b1);
    fill_random();
    run_pass(0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
